inst_encoder: RTL and testbench

- Inverse of the immediate-generation path: packs opcode, funct, register and immediate fields into a 32-bit RV32I instruction word.
- Range- and alignment-checks the immediate for the selected format.
- Tags each word with a sequential IMEM write address.
- Buffers results in a small output FIFO with valid/ready on both sides. Feeds the debug/boot loader that writes instruction memory.

---
 rtl/riscv_pkg.sv | 76 +++++++
 rtl/sync_fifo.sv | 51 +++++
 rtl/inst_encoder.sv | 80 ++++++++
 tb/tb_inst_encoder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// RV32I field packing shared by the instruction encoder and its bench.
// Format codes, common opcodes and the word-encode function.
package riscv_pkg;

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;
  localparam logic [2:0] FMT_R = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef struct packed {
    logic        err;
    logic [31:0] inst;
  } enc_t;

  // A slice is a valid sign extension when its AND equals its OR.
  function automatic enc_t encode(
    input logic [2:0]  fmt,
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    enc_t r;
    r.err  = 1'b0;
    r.inst = '0;
    unique case (1'b1)
      (fmt == FMT_I): begin
        r.inst = {imm[11:0], rs1, f3, rd, op};
        r.err  = (&imm[31:11]) != (|imm[31:11]);
      end
      (fmt == FMT_S): begin
        r.inst = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        r.err  = (&imm[31:11]) != (|imm[31:11]);
      end
      (fmt == FMT_B): begin
        r.inst = {imm[12], imm[10:5], rs2, rs1, f3,
                  imm[4:1], imm[11], op};
        r.err  = ((&imm[31:12]) != (|imm[31:12])) || imm[0];
      end
      (fmt == FMT_U): begin
        r.inst = {imm[31:12], rd, op};
        r.err  = |imm[11:0];
      end
      (fmt == FMT_J): begin
        r.inst = {imm[20], imm[10:1], imm[11],
                  imm[19:12], rd, op};
        r.err  = ((&imm[31:20]) != (|imm[31:20])) || imm[0];
      end
      (fmt == FMT_R): begin
        r.inst = {f7, rs2, rs1, f3, rd, op};
        r.err  = 1'b0;
      end
      default: begin
        r.inst = '0;
        r.err  = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with valid/ready on both sides.
// Output data reads as zero while empty.
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: contents are masked until written.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

endmodule

// File: rtl/inst_encoder.sv
// Packs RV32I fields into instruction words tagged with IMEM addresses,
// flags bad immediates and queues results for the boot loader.
module inst_encoder
  import riscv_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  localparam int WIDTH = 32 + ADDR_W + 1;

  enc_t              enc;
  logic              accept;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] push_addr;
  logic [WIDTH-1:0]  head;

  assign enc = encode(in_fmt, in_opcode, in_funct3, in_funct7,
                      in_rd, in_rs1, in_rs2, in_imm);

  assign accept    = in_valid && in_ready;
  assign push_addr = addr_load ? addr_base : addr_q;

  // A load coinciding with an accept hands the base to that word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (accept) begin
      addr_q <= push_addr + ADDR_W'(4);
    end else begin
      addr_q <= push_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (accept && enc.err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({enc.inst, push_addr, enc.err}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  assign {out_inst, out_addr, out_err} = head;

endmodule

// File: tb/tb_inst_encoder.sv
// Vector table plus scoreboard for inst_encoder: encodings, errors,
// address counter, backpressure, saturation and async reset.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        addr_load = 1'b0;
  logic [31:0] addr_base = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_cnt;

  inst_encoder #(.DEPTH(2), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .addr_load (addr_load),
    .addr_base (addr_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } sb_t;

  localparam int NV = 13;

  vec_t        tv [NV];
  vec_t        cur;
  vec_t        bad;
  sb_t         sb [$];
  logic [31:0] tb_addr = '0;
  int          m_err = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [2:0] fmt, input logic [6:0] op,
    input logic [2:0] f3, input logic [6:0] f7,
    input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic [31:0] imm,
    input logic [31:0] inst, input logic err);
    vec_t v;
    v.fmt = fmt; v.op = op; v.f3 = f3; v.f7 = f7;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.inst = inst; v.err = err;
    return v;
  endfunction

  // Scoreboard: pop on a pending pop, push on a pending accept.
  always @(negedge clk) begin
    sb_t         e;
    logic [31:0] a;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 64'(out_inst), 64'h0bad);
        end else begin
          e = sb.pop_front();
          chk("out_inst", 64'(out_inst), 64'(e.inst));
          chk("out_addr", 64'(out_addr), 64'(e.addr));
          chk("out_err", 64'(out_err), 64'(e.err));
        end
      end
      if (in_valid && in_ready) begin
        a = addr_load ? addr_base : tb_addr;
        e.inst = cur.inst;
        e.addr = a;
        e.err  = cur.err;
        sb.push_back(e);
        tb_addr = a + 32'd4;
        if (cur.err && m_err != 255) m_err++;
      end else if (addr_load) begin
        tb_addr = addr_base;
      end
    end
  end

  task automatic drive(input vec_t v);
    cur       = v;
    in_fmt    = v.fmt;
    in_opcode = v.op;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_imm    = v.imm;
    in_valid  = 1'b1;
  endtask

  task automatic send(input vec_t v);
    bit ok;
    ok = 1'b0;
    drive(v);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (sb.size() == 0) break;
    end
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = mk(3'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0,
                32'hFFFFFFFF, 32'hFFF00093, 1'b0);
    tv[1]  = mk(3'd2, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2,
                32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
    tv[2]  = mk(3'd4, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0,
                32'h00000800, 32'h001000EF, 1'b0);
    tv[3]  = mk(3'd3, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0,
                32'h12345000, 32'h123452B7, 1'b0);
    tv[4]  = mk(3'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0,
                32'h00000800, 32'h80000093, 1'b1);
    tv[5]  = mk(3'd2, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2,
                32'h00000005, 32'h00208263, 1'b1);
    tv[6]  = mk(3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0,
                32'h00000000, 32'h00000000, 1'b1);
    tv[7]  = mk(3'd1, 7'h23, 3'd2, 7'h00, 5'd0, 5'd2, 5'd5,
                32'hFFFFFFF8, 32'hFE512C23, 1'b0);
    tv[8]  = mk(3'd5, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2,
                32'h00000000, 32'h402081B3, 1'b0);
    tv[9]  = mk(3'd3, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0,
                32'h12345001, 32'h123452B7, 1'b1);
    tv[10] = mk(3'd4, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0,
                32'h00000003, 32'h0020006F, 1'b1);
    tv[11] = mk(3'd4, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0,
                32'h00100000, 32'h8000006F, 1'b1);
    tv[12] = mk(3'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0,
                32'hFFFFF800, 32'h80000093, 1'b0);
    bad    = mk(3'd6, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0,
                32'h00000000, 32'h00000000, 1'b1);

    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: each word must be visible one cycle after its accept.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      send(tv[i]);
      chk("latency_valid", 64'(out_valid), 64'd1);
      chk("err_cnt", 64'(err_cnt), 64'(m_err));
    end
    drain();

    // Backpressure with a full two-entry FIFO.
    out_ready = 1'b0;
    send(tv[0]);
    send(tv[7]);
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    chk("bp_valid", 64'(out_valid), 64'd1);
    drive(tv[8]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_inst", 64'(out_inst), 64'(tv[0].inst));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(tv[8]);
    drain();

    // Address load with and without a simultaneous accept.
    addr_load = 1'b1;
    addr_base = 32'h100;
    send(tv[8]);
    addr_load = 1'b0;
    send(tv[3]);
    addr_load = 1'b1;
    addr_base = 32'hFFFFFFFC;
    @(posedge clk);
    #1;
    addr_load = 1'b0;
    send(tv[0]);
    send(tv[2]);
    drain();

    // Error counter saturation.
    for (int i = 0; i < 258; i++) send(bad);
    drain();
    chk("err_cnt_sat", 64'(err_cnt), 64'd255);

    // Asynchronous reset with words queued.
    out_ready = 1'b0;
    send(tv[1]);
    send(tv[3]);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd1);
    chk("async_rst_inst", 64'(out_inst), 64'd0);
    sb.delete();
    tb_addr = '0;
    m_err = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(tv[2]);
    drain();
    chk("post_rst_err_cnt", 64'(err_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
